invert: RTL and testbench
=========================

# invert

Bit-serial two's-complement negator. A binary word arrives on `i` one bit per clock, least-significant bit first. `y` carries the negated word, also LSB first, in the same cycle. The rule is: pass bits through unchanged up to and including the first 1, then invert every later bit. The block sits on a serial datapath between a shift-out stage and a serial consumer, and adds no latency.

## Interface
- No parameters.
- `t_clk`, input, 1: single system clock. The flag register updates on the rising edge.
- `r`, input, 1: asynchronous active-low reset. While low, it clears and holds the "first-one-seen" flag. Driving it low also marks the start of a new word.
- `i`, input, 1: serial data in, LSB first. Sampled by the flag register on the rising edge of `t_clk`.
- `y`, output, 1: serial two's-complement data out, LSB first. Combinational from `i` and the flag.

Port order is `(i, r, t_clk, y)`.

## Operation
- There is one state bit, `seen`, with two states:
  - COPY (`seen` = 0).
  - INVERT (`seen` = 1).
- Output logic:
  - `y = i XOR seen`.
  - This is Mealy: the current bit is already resolved by the flag state from previous bits.
- State transitions on the rising edge of `t_clk`, with `r` high:
  - COPY with `i` = 1 goes to INVERT.
  - COPY with `i` = 0 stays in COPY.
  - INVERT stays in INVERT regardless of `i`.
- Reset:
  - `r` low forces COPY immediately, without waiting for a clock.
  - It holds COPY for as long as `r` is low.
  - During reset `y` equals `i`.
- Word boundary:
  - The block has no word-length counter.
  - A new word starts only when `r` is pulsed low between words.
  - Without a reset pulse, the block stays in INVERT and all later bits are inverted.
- Arithmetic:
  - The result is −x mod 2^N for whatever word length N the framing implies.
  - x = 0 gives 0.
  - x = 2^(N−1), the most negative value, returns itself.
- Power-up: `seen` is undefined until the first reset. Users must assert `r` low before the first word.
- Inputs `i` and `r` are the only state drivers. There are no other control inputs.

## Timing
- Latency is zero cycles. `y` for bit k appears in the same cycle bit k is presented, after combinational delay only.
- `i` must be stable around the rising edge of `t_clk`. The bit rate equals the `t_clk` rate: one bit per clock.
- The flag update takes effect after the clock edge. The bit that causes COPY→INVERT is itself output uncopied and uninverted (`y` = 1).
- Reset assertion:
  - Asynchronous, and applies immediately.
  - If `r` falls mid-word, `seen` clears at once. The remaining bits are treated as a fresh word.
- Reset deassertion:
  - Takes effect for the next rising edge.
  - If `r` rises in the same cycle as an `i` = 1 bit, that bit is output as 1, and `seen` sets on that edge when `r` is already high.
  - `r` must meet recovery time relative to `t_clk`.
- Reset and `i` = 1 on the same edge: reset wins, and `seen` stays 0.

## Test plan
- Reset behaviour: hold `r` = 0 and toggle `i` 0,1,0,1 across four edges. Required: `y` = 0,1,0,1 (pass-through), and `seen` remains 0.
- Basic negation, 4-bit x = 0110 (LSB first 0,1,1,0) after a reset pulse. Required: `y` = 0,1,0,1, i.e. 1010 = −6.
- First bit is 1, x = 0011 (stream 1,1,0,0). Required: `y` = 1,0,1,1, i.e. 1101 = −3.
- Zero and most-negative values:
  - Stream 0,0,0,0 gives `y` = 0,0,0,0.
  - Stream 0,0,0,1 (1000) gives `y` = 0,0,0,1.
- Back-to-back words: stream 1,0,1,0, pulse `r` low, then stream 0,1,0,0. Required: `y` = 1,1,0,1, then 0,1,1,1. Without the reset pulse, the second word must come out as 1,0,1,1 (fully inverted).
- Mid-word reset: stream 1,0 (INVERT reached), assert `r` low asynchronously between edges, release, then stream 0,1,1. Required: `y` drops to follow `i` immediately, and the remaining output is 0,1,0.

Source files
------------

// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first, zero latency.
// Copies bits through the first 1, then inverts all later bits.
module invert (
  input  logic i,
  input  logic r,
  input  logic t_clk,
  output logic y
);

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } state_t;

  state_t seen;

  // Latch the first 1 of the word; reset low marks a new word.
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      seen <= COPY;
    end else if (seen == COPY && i) begin
      seen <= INVERT;
    end
  end

  // Mealy output: the flag reflects earlier bits only.
  assign y = i ^ (seen == INVERT);

endmodule

// File: tb/tb_invert.sv
// Self-checking bench for the serial negator.
// Expected bits come from arithmetic negation of each word.
module tb_invert;

  logic t_clk = 1'b0;
  logic r = 1'b0;
  logic i = 1'b0;
  logic y;

  bit exp_q[$];
  int errors = 0;
  int checks = 0;

  invert dut (
    .i(i),
    .r(r),
    .t_clk(t_clk),
    .y(y)
  );

  always #10 t_clk = ~t_clk;

  // Entry and exit at a falling edge; bit held across rising edge.
  task automatic send(input bit b, input bit e, input string name);
    bit x;
    i = b;
    exp_q.push_back(e);
    #2;
    x = exp_q.pop_front();
    checks++;
    if (y !== x) begin
      errors++;
      $display("FAIL %s: y=%b expected %b", name, y, x);
    end
    @(posedge t_clk);
    @(negedge t_clk);
  endtask

  task automatic send_word(input logic [7:0] x, input logic [7:0] e,
                           input int n, input string name);
    for (int k = 0; k < n; k++) send(x[k], e[k], name);
  endtask

  task automatic pulse_reset();
    r = 1'b0;
    #1;
    r = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] s;
    s = 4'b1010;
    r = 1'b0;
    for (int k = 0; k < 4; k++) send(s[k], s[k], "reset_pass");
    r = 1'b1;
    send(1'b0, 1'b0, "reset_won");
  endtask

  task automatic test_negate();
    logic [3:0] w [4];
    logic [3:0] n4;
    w[0] = 4'b0110;
    w[1] = 4'b0011;
    w[2] = 4'b0000;
    w[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      n4 = 4'd0 - w[k];
      pulse_reset();
      send_word({4'd0, w[k]}, {4'd0, n4}, 4, "negate4");
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    send_word(8'h05, 8'h0b, 4, "b2b_first");
    pulse_reset();
    send_word(8'h02, 8'h0e, 4, "b2b_second");
    send_word(8'h02, {4'd0, ~4'h2}, 4, "b2b_noreset");
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    send(1'b1, 1'b1, "mid_first");
    send(1'b0, 1'b1, "mid_second");
    i = 1'b1;
    #1;
    checks++;
    if (y !== 1'b0) begin
      errors++;
      $display("FAIL mid_inverting: y=%b expected 0", y);
    end
    r = 1'b0;
    #1;
    checks++;
    if (y !== 1'b1) begin
      errors++;
      $display("FAIL mid_async: y=%b expected 1", y);
    end
    r = 1'b1;
    #1;
    send(1'b0, 1'b0, "mid_rest");
    send(1'b1, 1'b1, "mid_rest");
    send(1'b1, 1'b0, "mid_rest");
  endtask

  task automatic test_random();
    logic [7:0] x;
    logic [7:0] n8;
    for (int k = 0; k < 8; k++) begin
      x = 8'($urandom);
      if (k == 0) x = 8'h80;
      if (k == 1) x = 8'h01;
      n8 = 8'd0 - x;
      pulse_reset();
      send_word(x, n8, 8, "negate8");
    end
  endtask

  initial begin
    @(negedge t_clk);
    test_reset();
    test_negate();
    test_back_to_back();
    test_mid_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: left=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
